// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-control bundle between the PPU pipeline and hazard_ctrl_unit.
//   Inputs to the unit: ID source registers and use flags, the ID/EX, EX/MEM
//   and MEM/WB destination/write-enable info, and the EX branch outcome.
//   Outputs from the unit: PC / IF-ID load enables, IF-ID flush, ID-EX bubble,
//   forwarding selects and the statistics counters.
//   master: hazard_ctrl_unit side.  slave: pipeline side.
interface hazard_ctrl_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] ID_RA;
  logic [REG_AW-1:0] ID_RB;
  logic              ID_RA_USE;
  logic              ID_RB_USE;
  logic [REG_AW-1:0] EX_RD;
  logic              EX_L;
  logic              EX_RF_LE;
  logic              EX_BR_TAKEN;
  logic              EX_N;
  logic [REG_AW-1:0] MEM_RD;
  logic              MEM_RF_LE;
  logic [REG_AW-1:0] WB_RD;
  logic              WB_RF_LE;
  logic              PC_LE;
  logic              IF_ID_LE;
  logic              IF_ID_FLUSH;
  logic              ID_EX_BUBBLE;
  logic [1:0]        FWD_A;
  logic [1:0]        FWD_B;
  logic [CNT_W-1:0]  STALL_CNT;
  logic [CNT_W-1:0]  FLUSH_CNT;

  modport master (
    input  ID_RA, ID_RB, ID_RA_USE, ID_RB_USE,
    input  EX_RD, EX_L, EX_RF_LE, EX_BR_TAKEN, EX_N,
    input  MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE,
    output PC_LE, IF_ID_LE, IF_ID_FLUSH, ID_EX_BUBBLE,
    output FWD_A, FWD_B, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    output ID_RA, ID_RB, ID_RA_USE, ID_RB_USE,
    output EX_RD, EX_L, EX_RF_LE, EX_BR_TAKEN, EX_N,
    output MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE,
    input  PC_LE, IF_ID_LE, IF_ID_FLUSH, ID_EX_BUBBLE,
    input  FWD_A, FWD_B, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the ID/EX pipeline register of the PA-RISC PPU.
//   Detects load-use hazards (stall + bubble), squashes IF/ID (and optionally
//   the delay slot) on taken branches, and selects operand forwarding sources.
// Ports:
//   clk   - pipeline clock, rising edge
//   Reset - asynchronous active-low reset
//   bus   - hazard_ctrl_unit_if.master (pipeline status in, control out)
// Parameters: REG_AW register-number width, LOAD_STALL load-use hold length
//   (1..15 cycles), CNT_W statistics counter width.
// Build option: define HAZARD_STATS_EN to implement STALL_CNT / FLUSH_CNT;
//   otherwise both read as constant zero.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               Reset,
  hazard_ctrl_unit_if.master bus
);

  localparam int unsigned      STALL_W     = 4;
  localparam logic [STALL_W-1:0] STALL_INIT = STALL_W'(LOAD_STALL - 1);
  localparam bit               MULTI_STALL = (LOAD_STALL > 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_BR       = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;

  logic lu_hazard_c;
  logic pc_le_c, if_id_le_c, if_id_flush_c, id_ex_bubble_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Load-use: a load in EX targets a register the ID instruction reads (GR0 excluded).
  always_comb begin
    lu_hazard_c = bus.EX_L & bus.EX_RF_LE & (bus.EX_RD != '0) &
                  ((bus.ID_RA_USE & (bus.ID_RA == bus.EX_RD)) |
                   (bus.ID_RB_USE & (bus.ID_RB == bus.EX_RD)));
  end

  // First match wins: EX, then MEM, then WB; GR0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] ex_rd,
    input logic              ex_ok,
    input logic [REG_AW-1:0] mem_rd,
    input logic              mem_ok,
    input logic [REG_AW-1:0] wb_rd,
    input logic              wb_ok
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (ex_ok && (ex_rd == src))        sel = 2'b01;
      else if (mem_ok && (mem_rd == src)) sel = 2'b10;
      else if (wb_ok && (wb_rd == src))   sel = 2'b11;
    end
    return sel;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: branch outranks load-use; stall state ignores new events.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LU_STALL: begin
        if (cnt_q <= STALL_W'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - STALL_W'(1);
        end
      end
      default: begin
        if (bus.EX_BR_TAKEN) begin
          state_d = ST_BR;
        end else if (lu_hazard_c && MULTI_STALL) begin
          state_d = ST_LU_STALL;
          cnt_d   = STALL_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // Outputs: Mealy in RUN/BR, pure hold in LU_STALL, forced idle while in reset.
  always_comb begin
    pc_le_c        = 1'b1;
    if_id_le_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    fwd_a_c        = 2'b00;
    fwd_b_c        = 2'b00;
    if (Reset) begin
      fwd_a_c = fwd_sel(bus.ID_RA, bus.EX_RD, bus.EX_RF_LE & ~bus.EX_L,
                        bus.MEM_RD, bus.MEM_RF_LE, bus.WB_RD, bus.WB_RF_LE);
      fwd_b_c = fwd_sel(bus.ID_RB, bus.EX_RD, bus.EX_RF_LE & ~bus.EX_L,
                        bus.MEM_RD, bus.MEM_RF_LE, bus.WB_RD, bus.WB_RF_LE);
      unique case (state_q)
        ST_LU_STALL: begin
          pc_le_c        = 1'b0;
          if_id_le_c     = 1'b0;
          id_ex_bubble_c = 1'b1;
        end
        default: begin
          if (bus.EX_BR_TAKEN) begin
            // Target loads through PC; EX_N also squashes the delay slot in ID.
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = bus.EX_N;
          end else if (lu_hazard_c) begin
            pc_le_c        = 1'b0;
            if_id_le_c     = 1'b0;
            id_ex_bubble_c = 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.PC_LE        = pc_le_c;
  assign bus.IF_ID_LE     = if_id_le_c;
  assign bus.IF_ID_FLUSH  = if_id_flush_c;
  assign bus.ID_EX_BUBBLE = id_ex_bubble_c;
  assign bus.FWD_A        = fwd_a_c;
  assign bus.FWD_B        = fwd_b_c;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // A bubble without a flush is always a load-use bubble; both counters saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_ex_bubble_c && !if_id_flush_c && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (if_id_flush_c && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.STALL_CNT = stall_cnt_q;
  assign bus.FLUSH_CNT = flush_cnt_q;
`else
  assign bus.STALL_CNT = {CNT_W{1'b0}};
  assign bus.FLUSH_CNT = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: two instances (LOAD_STALL=1 and 3)
// share one stimulus stream; expected values are hand-computed.
module tb_hazard_ctrl_unit;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic [4:0] id_ra, id_rb, ex_rd, mem_rd, wb_rd;
  logic id_ra_use, id_rb_use, ex_l, ex_rf_le, ex_br_taken, ex_n, mem_rf_le, wb_rf_le;

  int n_cmp;
  int n_err;

  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) if1 ();
  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) if3 ();

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(16)) u_dut1 (
    .clk   (clk),
    .Reset (rst_n),
    .bus   (if1)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(16)) u_dut3 (
    .clk   (clk),
    .Reset (rst_n),
    .bus   (if3)
  );

  assign if1.ID_RA = id_ra;         assign if3.ID_RA = id_ra;
  assign if1.ID_RB = id_rb;         assign if3.ID_RB = id_rb;
  assign if1.ID_RA_USE = id_ra_use; assign if3.ID_RA_USE = id_ra_use;
  assign if1.ID_RB_USE = id_rb_use; assign if3.ID_RB_USE = id_rb_use;
  assign if1.EX_RD = ex_rd;         assign if3.EX_RD = ex_rd;
  assign if1.EX_L = ex_l;           assign if3.EX_L = ex_l;
  assign if1.EX_RF_LE = ex_rf_le;   assign if3.EX_RF_LE = ex_rf_le;
  assign if1.EX_BR_TAKEN = ex_br_taken; assign if3.EX_BR_TAKEN = ex_br_taken;
  assign if1.EX_N = ex_n;           assign if3.EX_N = ex_n;
  assign if1.MEM_RD = mem_rd;       assign if3.MEM_RD = mem_rd;
  assign if1.MEM_RF_LE = mem_rf_le; assign if3.MEM_RF_LE = mem_rf_le;
  assign if1.WB_RD = wb_rd;         assign if3.WB_RD = wb_rd;
  assign if1.WB_RF_LE = wb_rf_le;   assign if3.WB_RF_LE = wb_rf_le;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_ra = '0; id_rb = '0; id_ra_use = 1'b0; id_rb_use = 1'b0;
    ex_rd = '0; ex_l = 1'b0; ex_rf_le = 1'b0; ex_br_taken = 1'b0; ex_n = 1'b0;
    mem_rd = '0; mem_rf_le = 1'b0; wb_rd = '0; wb_rf_le = 1'b0;
  endtask

  // Load in EX writing r5, ID reads r5 via RA.
  task automatic load_use();
    idle();
    ex_l = 1'b1; ex_rf_le = 1'b1; ex_rd = 5'd5;
    id_ra = 5'd5; id_ra_use = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset with a live hazard and forward match on the inputs: outputs must stay idle.
    rst_n = 1'b0;
    load_use();
    mem_rd = 5'd5; mem_rf_le = 1'b1;
    next_cycle();
    next_cycle();
    sample();
    chk("rst_pc_le",    32'(if1.PC_LE), 32'd1);
    chk("rst_if_id_le", 32'(if3.IF_ID_LE), 32'd1);
    chk("rst_bubble",   32'(if1.ID_EX_BUBBLE), 32'd0);
    chk("rst_flush",    32'(if1.IF_ID_FLUSH), 32'd0);
    chk("rst_fwd_a",    32'(if1.FWD_A), 32'd0);
    chk("rst_stall_cnt", 32'(if1.STALL_CNT), 32'd0);
    chk("rst_flush_cnt", 32'(if3.FLUSH_CNT), 32'd0);

    next_cycle();
    idle();
    rst_n = 1'b1;
    next_cycle();

    // Load-use: cycle 0 hazard detected (both instances stall).
    load_use();
    sample();
    chk("lu0_pc_le_1",  32'(if1.PC_LE), 32'd0);
    chk("lu0_ifid_le_1", 32'(if1.IF_ID_LE), 32'd0);
    chk("lu0_bubble_1", 32'(if1.ID_EX_BUBBLE), 32'd1);
    chk("lu0_pc_le_3",  32'(if3.PC_LE), 32'd0);
    next_cycle();
    // Cycle 1: bubble in EX, load in MEM.
    idle();
    id_ra = 5'd5; id_ra_use = 1'b1; mem_rd = 5'd5; mem_rf_le = 1'b1;
    sample();
    chk("lu1_pc_le_1",  32'(if1.PC_LE), 32'd1);
    chk("lu1_bubble_1", 32'(if1.ID_EX_BUBBLE), 32'd0);
    chk("lu1_fwd_a_1",  32'(if1.FWD_A), 32'd2);
    chk("lu1_pc_le_3",  32'(if3.PC_LE), 32'd0);
    chk("lu1_bubble_3", 32'(if3.ID_EX_BUBBLE), 32'd1);
    chk("lu1_stall_cnt_1", 32'(if1.STALL_CNT), STATS ? 32'd1 : 32'd0);
    next_cycle();
    // Cycle 2: load now in WB.
    idle();
    id_ra = 5'd5; id_ra_use = 1'b1; wb_rd = 5'd5; wb_rf_le = 1'b1;
    sample();
    chk("lu2_fwd_a_1",  32'(if1.FWD_A), 32'd3);
    chk("lu2_pc_le_3",  32'(if3.PC_LE), 32'd0);
    chk("lu2_stall_cnt_3", 32'(if3.STALL_CNT), STATS ? 32'd2 : 32'd0);
    next_cycle();
    // Cycle 3: LOAD_STALL=3 instance released.
    idle();
    sample();
    chk("lu3_pc_le_3",  32'(if3.PC_LE), 32'd1);
    chk("lu3_bubble_3", 32'(if3.ID_EX_BUBBLE), 32'd0);
    chk("lu3_stall_cnt_3", 32'(if3.STALL_CNT), STATS ? 32'd3 : 32'd0);
    chk("lu3_stall_cnt_1", 32'(if1.STALL_CNT), STATS ? 32'd1 : 32'd0);
    next_cycle();

    // Taken branch, no nullify.
    idle();
    ex_br_taken = 1'b1;
    sample();
    chk("br_flush",  32'(if1.IF_ID_FLUSH), 32'd1);
    chk("br_bubble", 32'(if1.ID_EX_BUBBLE), 32'd0);
    chk("br_pc_le",  32'(if1.PC_LE), 32'd1);
    next_cycle();
    idle();
    sample();
    chk("br_flush_off", 32'(if1.IF_ID_FLUSH), 32'd0);
    chk("br_flush_cnt1", 32'(if1.FLUSH_CNT), STATS ? 32'd1 : 32'd0);
    next_cycle();

    // Taken branch with nullify squashes the delay slot too.
    idle();
    ex_br_taken = 1'b1; ex_n = 1'b1;
    sample();
    chk("brn_flush",  32'(if1.IF_ID_FLUSH), 32'd1);
    chk("brn_bubble", 32'(if1.ID_EX_BUBBLE), 32'd1);
    next_cycle();
    idle();
    sample();
    chk("brn_flush_cnt2", 32'(if1.FLUSH_CNT), STATS ? 32'd2 : 32'd0);
    chk("brn_stall_cnt",  32'(if1.STALL_CNT), STATS ? 32'd1 : 32'd0);
    next_cycle();

    // Branch and load-use together: branch wins, no stall.
    load_use();
    ex_br_taken = 1'b1;
    sample();
    chk("brlu_pc_le",  32'(if3.PC_LE), 32'd1);
    chk("brlu_flush",  32'(if3.IF_ID_FLUSH), 32'd1);
    chk("brlu_bubble", 32'(if3.ID_EX_BUBBLE), 32'd0);
    next_cycle();
    idle();
    sample();
    chk("brlu_after_pc_le", 32'(if3.PC_LE), 32'd1);
    chk("brlu_flush_cnt3",  32'(if3.FLUSH_CNT), STATS ? 32'd3 : 32'd0);
    next_cycle();

    // Branch during LU_STALL is ignored by the LOAD_STALL=3 instance.
    load_use();
    sample();
    next_cycle();
    idle();
    ex_br_taken = 1'b1; ex_n = 1'b1;
    sample();
    chk("stbr_flush_3", 32'(if3.IF_ID_FLUSH), 32'd0);
    chk("stbr_pc_le_3", 32'(if3.PC_LE), 32'd0);
    chk("stbr_flush_1", 32'(if1.IF_ID_FLUSH), 32'd1);
    next_cycle();
    idle();
    sample();
    chk("stbr_hold_3", 32'(if3.PC_LE), 32'd0);
    next_cycle();
    sample();
    chk("stbr_done_3", 32'(if3.PC_LE), 32'd1);
    next_cycle();

    // Forwarding priority on source B (combinational).
    idle();
    ex_rd = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
    ex_rf_le = 1'b1; mem_rf_le = 1'b1; wb_rf_le = 1'b1;
    id_rb = 5'd7;
    #1 chk("fwd_b_ex", 32'(if1.FWD_B), 32'd1);
    ex_rf_le = 1'b0;
    #1 chk("fwd_b_mem", 32'(if1.FWD_B), 32'd2);
    mem_rf_le = 1'b0;
    #1 chk("fwd_b_wb", 32'(if1.FWD_B), 32'd3);
    mem_rf_le = 1'b1; ex_rf_le = 1'b1; ex_l = 1'b1;
    #1 chk("fwd_b_load_ex", 32'(if1.FWD_B), 32'd2);
    ex_l = 1'b0; id_rb = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    #1 chk("fwd_b_gr0", 32'(if1.FWD_B), 32'd0);
    chk("fwd_a_none", 32'(if1.FWD_A), 32'd0);
    next_cycle();

    // Reset asserted in the 2nd cycle of a 3-cycle stall.
    load_use();
    sample();
    next_cycle();
    sample();
    chk("rstst_pre_pc_le", 32'(if3.PC_LE), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstst_pc_le",  32'(if3.PC_LE), 32'd1);
    chk("rstst_bubble", 32'(if3.ID_EX_BUBBLE), 32'd0);
    chk("rstst_ifid",   32'(if3.IF_ID_LE), 32'd1);
    chk("rstst_scnt",   32'(if3.STALL_CNT), 32'd0);
    chk("rstst_fcnt",   32'(if3.FLUSH_CNT), 32'd0);
    next_cycle();
    idle();
    rst_n = 1'b1;
    next_cycle();
    sample();
    chk("rstst_run_pc_le", 32'(if3.PC_LE), 32'd1);
    chk("rstst_run_scnt",  32'(if3.STALL_CNT), 32'd0);
    chk("rstst_run_fcnt",  32'(if1.FLUSH_CNT), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
